ctrl_decode_seq: RTL

// - Parametrised, sequenced successor to the flat pi/po control decoder.
// - Accepts {op,fn} instruction fields over valid/ready and looks them up in a run-time programmable decode table.
// - Emits a registered control word with a tag; entries flagged multi-cycle stall the issue path for MC_LAT cycles.
// - Sits between instruction fetch and the datapath; software loads the table after reset.

---
 rtl/ctrl_decode_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ctrl_decode_seq.sv
// Sequenced {op,fn} control decoder with a run-time programmable table and multi-cycle stall.
// Define CTRL_DECODE_PERF_EN to add saturating handshake counters cnt_issued / cnt_illegal.
module ctrl_decode_seq #(
  parameter int OP_W   = 3,
  parameter int FN_W   = 4,
  parameter int CW_W   = 26,
  parameter int MC_LAT = 4,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [FN_W-1:0]      in_fn,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CW_W-1:0]      out_cw,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_illegal,
  input  logic                 tbl_we,
  input  logic [OP_W+FN_W-1:0] tbl_addr,
  input  logic [CW_W+1:0]      tbl_wdata,
  output logic                 busy
`ifdef CTRL_DECODE_PERF_EN
  ,
  output logic [15:0]          cnt_issued,
  output logic [15:0]          cnt_illegal
`endif
);

  localparam int AW    = OP_W + FN_W;
  localparam int DEPTH = 1 << AW;
  localparam int EW    = CW_W + 2;
  localparam int CNT_W = $clog2(MC_LAT) + 1;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [EW-1:0]    tbl_q [DEPTH];
  logic [EW-1:0]    tbl_d [DEPTH];
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW_W-1:0]  out_cw_q, out_cw_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_illegal_q, out_illegal_d;

  logic [EW-1:0]    entry;
  logic             entry_vld;
  logic             entry_multi;
  logic             accept;

  // Lookup reads the registered table, so a same-cycle write is seen only by later accepts.
  assign entry       = tbl_q[{in_op, in_fn}];
  assign entry_vld   = entry[CW_W+1];
  assign entry_multi = entry[CW_W] & entry_vld;

  assign in_ready  = (state_q == S_EMPTY) | ((state_q == S_FULL) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_FULL);
  assign busy      = (state_q != S_EMPTY);

  assign out_cw      = out_cw_q;
  assign out_tag     = out_tag_q;
  assign out_illegal = out_illegal_q;

  always_comb begin
    tbl_d = tbl_q;
    if (tbl_we) tbl_d[tbl_addr] = tbl_wdata;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_cw_d      = out_cw_q;
    out_tag_d     = out_tag_q;
    out_illegal_d = out_illegal_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) state_d = S_FULL;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      S_FULL: begin
        if (out_ready && !in_valid) state_d = S_EMPTY;
      end
      S_EMPTY: ;
      default: state_d = S_EMPTY;
    endcase
    // Accept is only possible from EMPTY or from FULL while draining.
    if (accept) begin
      state_d       = entry_multi ? S_WAIT : S_FULL;
      cnt_d         = entry_multi ? CNT_W'(MC_LAT - 1) : '0;
      out_cw_d      = entry_vld ? entry[CW_W-1:0] : '0;
      out_tag_d     = in_tag;
      out_illegal_d = ~entry_vld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      state_q       <= S_EMPTY;
      cnt_q         <= '0;
      out_cw_q      <= '0;
      out_tag_q     <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      tbl_q         <= tbl_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_cw_q      <= out_cw_d;
      out_tag_q     <= out_tag_d;
      out_illegal_q <= out_illegal_d;
    end
  end

`ifdef CTRL_DECODE_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic [15:0] cnt_issued_q, cnt_issued_d;
  logic [15:0] cnt_illegal_q, cnt_illegal_d;
  logic        hs;

  assign hs = out_valid & out_ready;

  always_comb begin
    cnt_issued_d  = sat_inc(cnt_issued_q, hs);
    cnt_illegal_d = sat_inc(cnt_illegal_q, hs & out_illegal_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_issued_q  <= '0;
      cnt_illegal_q <= '0;
    end else begin
      cnt_issued_q  <= cnt_issued_d;
      cnt_illegal_q <= cnt_illegal_d;
    end
  end

  assign cnt_issued  = cnt_issued_q;
  assign cnt_illegal = cnt_illegal_q;
`endif

endmodule
